// File: rtl/pipe_sel_mux.sv
// N:1 selection mux with registered output and a 2-entry skid buffer.
// Channel chosen by sel (MODE 0) or lowest-index valid (MODE 1); beats leave in strict FIFO order.
`timescale 1ns/1ps

module pipe_sel_mux #(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = 2,
   parameter int MODE   = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic [NUM_IN*WIDTH-1:0]  in_data,
   input  logic [NUM_IN-1:0]        in_valid,
   output logic [NUM_IN-1:0]        in_ready,
   input  logic [SEL_W-1:0]         sel,
   output logic [WIDTH-1:0]         out_data,
   output logic [SEL_W-1:0]         out_src,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     sel_err
);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t              state;
   state_t              state_nxt;
   logic                ch_ok;
   logic [SEL_W-1:0]    ch;
   logic [NUM_IN-1:0]   ch_hot;
   logic [WIDTH-1:0]    ch_data;
   logic                acc;
   logic                drn;
   logic [WIDTH-1:0]    sr_data;
   logic [SEL_W-1:0]    sr_src;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      ch_ok   = 1'b0;
      ch      = '0;
      ch_hot  = '0;
      ch_data = '0;
      if (MODE == 0) begin
         ch_ok = (32'(sel) < NUM_IN);
         ch    = sel;
      end else begin
         for (int i = NUM_IN - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
               ch_ok = 1'b1;
               ch    = SEL_W'(i);
            end
         end
      end
      for (int i = 0; i < NUM_IN; i++) begin
         ch_hot[i] = ch_ok && (ch == SEL_W'(i));
         if (ch_hot[i]) ch_data = in_data[i*WIDTH +: WIDTH];
      end
   end

   // Ready is a function of registered state only, keeping out_ready off the in_ready path.
   always_comb begin
      out_valid = (state != EMPTY);
      in_ready  = (state != TWO) ? ch_hot : '0;
   end

   assign acc = |(in_valid & in_ready);
   assign drn = out_valid & out_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY:   if (acc) state_nxt = ONE;
         ONE: begin
            if (acc && !drn)      state_nxt = TWO;
            else if (!acc && drn) state_nxt = EMPTY;
         end
         TWO:     if (drn) state_nxt = ONE;
         default: state_nxt = EMPTY;
      endcase
      if (flush) state_nxt = EMPTY;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nxt;
   end

   // NOTE: the two-entry storage is plain flops, so it is reset like any other register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data <= '0;
         out_src  <= '0;
         sr_data  <= '0;
         sr_src   <= '0;
      end else if (flush) begin
         out_data <= '0;
         out_src  <= '0;
         sr_data  <= '0;
         sr_src   <= '0;
      end else begin
         case (state)
            EMPTY: begin
               if (acc) begin
                  out_data <= ch_data;
                  out_src  <= ch;
               end
            end
            ONE: begin
               if (acc && drn) begin
                  out_data <= ch_data;
                  out_src  <= ch;
               end else if (acc) begin
                  sr_data <= ch_data;
                  sr_src  <= ch;
               end
            end
            TWO: begin
               if (drn) begin
                  out_data <= sr_data;
                  out_src  <= sr_src;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sel_err <= 1'b0;
      else        sel_err <= (MODE == 0) && (32'(sel) >= NUM_IN);
   end

endmodule

// File: tb/tb_pipe_sel_mux.sv
// Bench for pipe_sel_mux: three instances (explicit 4-way, priority 4-way, explicit 3-way)
// share stimulus and are compared every cycle against a queue model, plus directed literal checks.
`timescale 1ns/1ps

module tb_pipe_sel_mux;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic [127:0]  in_data;
   logic [3:0]    in_valid;
   logic [1:0]    sel;
   logic          out_ready;

   logic [31:0]   od0, od1, od2;
   logic [1:0]    os0, os1, os2;
   logic          ov0, ov1, ov2;
   logic          se0, se1, se2;
   logic [3:0]    ir0, ir1;
   logic [2:0]    ir2;

   int            n_checks = 0;
   int            n_errors = 0;

   // model: up to two queued beats per instance
   int            cnt [3];
   logic [31:0]   qd  [3][2];
   logic [1:0]    qs  [3][2];
   logic          mse [3];
   bit            rst_hit;

   pipe_sel_mux #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
      .in_ready(ir0), .sel(sel), .out_data(od0), .out_src(os0), .out_valid(ov0),
      .out_ready(out_ready), .sel_err(se0));

   pipe_sel_mux #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
      .in_ready(ir1), .sel(sel), .out_data(od1), .out_src(os1), .out_valid(ov1),
      .out_ready(out_ready), .sel_err(se1));

   pipe_sel_mux #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .MODE(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data[95:0]), .in_valid(in_valid[2:0]),
      .in_ready(ir2), .sel(sel), .out_data(od2), .out_src(os2), .out_valid(ov2),
      .out_ready(out_ready), .sel_err(se2));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int mode_of(input int k);
      return (k == 1) ? 1 : 0;
   endfunction

   function automatic int nin_of(input int k);
      return (k == 2) ? 3 : 4;
   endfunction

   task automatic pick(input int k, output bit ok, output int ch);
      ok = 0;
      ch = 0;
      if (mode_of(k) == 0) begin
         if (int'(sel) < nin_of(k)) begin
            ok = 1;
            ch = int'(sel);
         end
      end else begin
         for (int i = 0; i < nin_of(k); i++) begin
            if (in_valid[i]) begin
               ok = 1;
               ch = i;
               break;
            end
         end
      end
   endtask

   task automatic model_step(input int k);
      bit ok;
      int ch;
      bit acc;
      bit drn;
      pick(k, ok, ch);
      acc = ok && in_valid[ch] && (cnt[k] < 2);
      drn = (cnt[k] > 0) && out_ready;
      mse[k] = (mode_of(k) == 0) && (int'(sel) >= nin_of(k));
      if (flush) begin
         cnt[k] = 0;
      end else begin
         if (drn) begin
            qd[k][0] = qd[k][1];
            qs[k][0] = qs[k][1];
            cnt[k]--;
         end
         if (acc) begin
            qd[k][cnt[k]] = in_data[ch*32 +: 32];
            qs[k][cnt[k]] = 2'(ch);
            cnt[k]++;
         end
      end
   endtask

   task automatic fetch(input int k, output logic [31:0] d, output logic [1:0] s,
                        output logic v, output logic e, output logic [3:0] r);
      case (k)
         0:       begin d = od0; s = os0; v = ov0; e = se0; r = ir0; end
         1:       begin d = od1; s = os1; v = ov1; e = se1; r = ir1; end
         default: begin d = od2; s = os2; v = ov2; e = se2; r = {1'b0, ir2}; end
      endcase
   endtask

   task automatic compare(input int k);
      logic [31:0] d;
      logic [1:0]  s;
      logic        v;
      logic        e;
      logic [3:0]  r;
      bit          ok;
      int          ch;
      logic [3:0]  exp_r;
      fetch(k, d, s, v, e, r);
      pick(k, ok, ch);
      exp_r = (ok && cnt[k] < 2) ? (4'b0001 << ch) : 4'b0000;
      check($sformatf("dut%0d out_valid", k), 32'(v), 32'(cnt[k] > 0));
      check($sformatf("dut%0d in_ready", k), 32'(r), 32'(exp_r));
      check($sformatf("dut%0d sel_err", k), 32'(e), 32'(mse[k]));
      if (cnt[k] > 0) begin
         check($sformatf("dut%0d out_data", k), d, qd[k][0]);
         check($sformatf("dut%0d out_src", k), 32'(s), 32'(qs[k][0]));
      end
   endtask

   // Inputs change only at negedge+1, so at a negedge they still equal what the last posedge sampled.
   initial forever begin
      @(negedge rst_n);
      rst_hit = 1;
   end

   initial forever begin
      @(negedge clk);
      if (rst_hit || !rst_n) begin
         for (int k = 0; k < 3; k++) begin
            cnt[k] = 0;
            mse[k] = 1'b0;
         end
         rst_hit = 0;
      end
      if (rst_n) begin
         for (int k = 0; k < 3; k++) model_step(k);
         for (int k = 0; k < 3; k++) compare(k);
      end
   end

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic set_ch(input int c, input logic [31:0] v);
      in_data[c*32 +: 32] = v;
   endtask

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_data   = '0;
      in_valid  = '0;
      sel       = 2'd0;
      out_ready = 1'b0;
      repeat (3) cyc();
      check("reset out_data", od0, 32'h0);
      check("reset out_src", 32'(os0), 32'd0);
      check("reset out_valid", 32'({ov0, ov1, ov2}), 32'd0);
      check("reset sel_err", 32'({se0, se1, se2}), 32'd0);

      // simple pass
      rst_n = 1'b1;
      sel = 2'd2;
      set_ch(2, 32'hA5A5A5A5);
      in_valid = 4'b0100;
      out_ready = 1'b1;
      cyc();
      check("pass out_data", od0, 32'hA5A5A5A5);
      check("pass out_src", 32'(os0), 32'd2);
      check("pass out_valid", 32'(ov0), 32'd1);
      in_valid = 4'b0000;
      cyc();
      check("pass drained", 32'(ov0), 32'd0);

      // backpressure into the skid entry
      out_ready = 1'b0;
      sel = 2'd0;
      set_ch(0, 32'h11111111);
      in_valid = 4'b0001;
      cyc();
      sel = 2'd1;
      set_ch(1, 32'h22222222);
      in_valid = 4'b0010;
      cyc();
      check("skid in_ready dut0", 32'(ir0), 32'd0);
      check("skid in_ready dut1", 32'(ir1), 32'd0);
      check("skid out_data", od0, 32'h11111111);
      in_valid = 4'b0000;
      cyc();
      check("skid hold", od0, 32'h11111111);
      out_ready = 1'b1;
      check("skid first src", 32'(os0), 32'd0);
      cyc();
      check("skid second data", od0, 32'h22222222);
      check("skid second src", 32'(os0), 32'd1);
      cyc();
      check("skid empty", 32'(ov0), 32'd0);

      // streaming on channel 3
      sel = 2'd3;
      in_valid = 4'b1000;
      for (int i = 0; i < 8; i++) begin
         set_ch(3, 32'(i));
         cyc();
         check("stream data", od0, 32'(i));
         check("stream ready", 32'(ir0[3]), 32'd1);
      end
      in_valid = 4'b0000;
      cyc();
      check("stream drained", 32'(ov0), 32'd0);

      // priority mode
      sel = 2'd1;
      set_ch(1, 32'hDEADBEEF);
      set_ch(3, 32'hCAFEF00D);
      in_valid = 4'b1010;
      cyc();
      check("prio first data", od1, 32'hDEADBEEF);
      check("prio first src", 32'(os1), 32'd1);
      in_valid = 4'b1000;
      cyc();
      check("prio second data", od1, 32'hCAFEF00D);
      check("prio second src", 32'(os1), 32'd3);
      check("prio sel_err", 32'(se1), 32'd0);
      in_valid = 4'b0000;
      cyc();

      // out-of-range select on the 3-way instance
      sel = 2'd3;
      in_valid = 4'b0111;
      #1;
      check("oor in_ready", 32'(ir2), 32'd0);
      cyc();
      check("oor sel_err", 32'(se2), 32'd1);
      check("oor out_valid", 32'(ov2), 32'd0);
      cyc();
      check("oor still empty", 32'(ov2), 32'd0);
      in_valid = 4'b0000;
      sel = 2'd0;
      cyc();

      // flush while full, with a drain handshake in the same cycle
      out_ready = 1'b0;
      set_ch(0, 32'h000000F1);
      in_valid = 4'b0001;
      cyc();
      set_ch(0, 32'h000000F2);
      cyc();
      check("flush full", od0, 32'h000000F1);
      flush = 1'b1;
      out_ready = 1'b1;
      set_ch(0, 32'h000000F3);
      cyc();
      check("flush out_valid", 32'({ov0, ov1, ov2}), 32'd0);
      flush = 1'b0;
      in_valid = 4'b0000;
      cyc();
      check("flush nothing out", 32'(ov0), 32'd0);

      // flush in ONE while accepting and draining
      set_ch(0, 32'h000000F4);
      in_valid = 4'b0001;
      cyc();
      check("flush one loaded", od0, 32'h000000F4);
      flush = 1'b1;
      set_ch(0, 32'h000000F5);
      cyc();
      check("flush one dropped", 32'(ov0), 32'd0);
      flush = 1'b0;
      in_valid = 4'b0000;
      cyc();
      check("flush one stays empty", 32'(ov0), 32'd0);

      // asynchronous reset between edges
      out_ready = 1'b0;
      set_ch(0, 32'h000000AA);
      in_valid = 4'b0001;
      cyc();
      set_ch(0, 32'h000000BB);
      cyc();
      in_valid = 4'b0000;
      check("arst refill", 32'(ov0), 32'd1);
      rst_n = 1'b0;
      #1;
      check("arst out_valid", 32'({ov0, ov1, ov2}), 32'd0);
      check("arst out_data", od0, 32'h0);
      #2;
      rst_n = 1'b1;
      cyc();
      check("arst stays empty", 32'(ov0), 32'd0);

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         in_data   = {$urandom, $urandom, $urandom, $urandom};
         in_valid  = 4'($urandom);
         sel       = 2'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
